instr_fetch_queue: RTL

- Decoupling buffer between the fetch unit and the decode stage of the pipelined MIPS core.
- Captures {PC, instruction} pairs from fetch at one per cycle and presents them in order to decode, which pops them when ready.
- Absorbs decode stalls without stopping fetch until the buffer is full.
- A flush input discards all buffered entries on a branch, jump or jr redirect.

---
 rtl/instr_fetch_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Decoupling FIFO between the fetch unit and the decode stage. Fetch pushes
// {PC, instruction} pairs at up to one per cycle. Decode sees the oldest pair
// on D_* and pops it when it is ready. Flush empties the queue on a redirect.
//
// Ports:
//   CLK      rising-edge clock
//   Reset    asynchronous, active-high reset
//   F_Push   fetch offers {F_PC, F_Instr} this cycle
//   F_Instr  instruction word from fetch
//   F_PC     address of F_Instr
//   D_Pop    decode consumes the head entry this cycle
//   Flush    discard every buffered entry (takes priority over push/pop)
//   F_Full   queue cannot take a push unless a pop happens in the same cycle
//   D_Valid  head entry valid
//   D_Instr  head instruction, nop (0) when empty
//   D_PC     head PC, RESET_PC when empty
//   D_PC8    D_PC + 8, the jal link value
//   Count    number of valid entries, 0..DEPTH
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          F_Push,
  input  logic [31:0]   F_Instr,
  input  logic [31:0]   F_PC,
  input  logic          D_Pop,
  input  logic          Flush,
  output logic          F_Full,
  output logic          D_Valid,
  output logic [31:0]   D_Instr,
  output logic [31:0]   D_PC,
  output logic [31:0]   D_PC8,
  output logic [AW:0]   Count
);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [31:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;

  logic          empty_s;
  logic          full_s;
  logic          pop_ok_s;
  logic          push_ok_s;
  logic [AW:0]   count_next_s;

  assign empty_s   = (count_r == '0);
  assign full_s    = (count_r == FULL_COUNT);
  assign pop_ok_s  = D_Pop & ~empty_s;
  // A push into a full queue is kept only when the head leaves in the same cycle.
  assign push_ok_s = F_Push & (~full_s | pop_ok_s);

  // Occupancy update for a non-flush edge.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and count registers; flush returns them to the reset origin.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (Flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge CLK) begin
    if (push_ok_s && !Flush) begin
      pc_mem_r[wr_ptr_r]    <= F_PC;
      instr_mem_r[wr_ptr_r] <= F_Instr;
    end
  end

  // Decode-side view of the head entry, with fixed values while empty.
  always_comb begin
    D_Valid = ~empty_s;
    F_Full  = full_s;
    Count   = count_r;
    if (empty_s) begin
      D_Instr = 32'h0000_0000;
      D_PC    = RESET_PC;
    end else begin
      D_Instr = instr_mem_r[rd_ptr_r];
      D_PC    = pc_mem_r[rd_ptr_r];
    end
    D_PC8 = D_PC + 32'd8;
  end

endmodule
